// File: rtl/axi_to_mem_pkg.sv
// Shared definitions for the axi_to_mem bridge: R-channel response codes and beat sizing.
// Latency: none (package only).
// Backpressure: not applicable.
package axi_to_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Width of a packed R beat {id, data, resp[1:0], last, user}. The spill register uses it too.
  function automatic int unsigned r_beat_width(input int unsigned id_w,
                                               input int unsigned data_w,
                                               input int unsigned user_w);
    return id_w + data_w + 3 + user_w;
  endfunction

endpackage

// File: rtl/axi_to_mem_fifo.sv
// Synchronous FIFO with full/empty flags and an occupancy count.
// Latency: a pushed entry is visible at data_o in the cycle after the push.
// Backpressure: a push while full is ignored, and a pop while empty is ignored.
module axi_to_mem_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  // Next pointer/count state; a power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && !empty_o;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + PtrW'(1);
    if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset discards every buffered entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage write; contents need no reset because the count guards every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_to_mem_r_assembler.sv
// Joins per-beat read metadata with memory read data to form AXI R beats.
// Latency: a beat is valid one cycle after its data (or its error metadata) arrives.
// Backpressure: r_ready_i stalls the heads; the memory side is never stalled, and data that arrives while the data FIFO is full is dropped and flagged.
module axi_to_mem_r_assembler
  import axi_to_mem_pkg::*;
#(
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned UserWidth      = 1,
  parameter int unsigned NumOutstanding = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                meta_valid_i,
  output logic                                meta_ready_o,
  input  logic [IdWidth-1:0]                  meta_id_i,
  input  logic                                meta_last_i,
  input  logic [UserWidth-1:0]                meta_user_i,
  input  logic                                meta_err_i,
  input  logic                                mem_rvalid_i,
  input  logic [DataWidth-1:0]                mem_rdata_i,
  input  logic                                mem_err_i,
  output logic                                r_valid_o,
  input  logic                                r_ready_i,
  output logic [IdWidth+DataWidth+3+UserWidth-1:0] r_data_o,
  output logic [$clog2(NumOutstanding):0]     outstanding_o,
  output logic                                overflow_o
);

  localparam int MetaW  = IdWidth + 2 + UserWidth;
  localparam int DataEW = DataWidth + 1;
  localparam int BeatW  = int'(r_beat_width(IdWidth, DataWidth, UserWidth));
  localparam int CntW   = $clog2(NumOutstanding) + 1;

  // Meta entry {id, last, user, err}; data entry {data, mem_err}.
  logic [MetaW-1:0]  meta_in, meta_head;
  logic [DataEW-1:0] data_in, data_head;
  logic              meta_full, meta_empty, data_full, data_empty;
  logic              meta_push, data_push, meta_pop, data_pop;
  logic [CntW-1:0]   data_count_unused;

  logic [IdWidth-1:0]   head_id;
  logic                 head_last;
  logic [UserWidth-1:0] head_user;
  logic                 head_err;
  logic [DataWidth-1:0] beat_data;
  logic [1:0]           beat_resp;
  logic [BeatW-1:0]     beat;
  logic                 fire;
  logic                 overflow_q, overflow_d;

  assign meta_in   = {meta_id_i, meta_last_i, meta_user_i, meta_err_i};
  assign data_in   = {mem_rdata_i, mem_err_i};
  assign head_err  = meta_head[0];
  assign head_user = meta_head[UserWidth:1];
  assign head_last = meta_head[UserWidth+1];
  assign head_id   = meta_head[MetaW-1 -: IdWidth];

  // Ready comes only from registered occupancy, so there is no ready-to-valid loop.
  assign meta_ready_o = !meta_full;
  assign meta_push    = meta_valid_i && !meta_full;
  assign data_push    = mem_rvalid_i && !data_full;
  assign meta_pop     = fire;
  assign data_pop     = fire && !head_err;

  axi_to_mem_fifo #(.Width(MetaW), .Depth(NumOutstanding)) u_meta_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (meta_push),
    .data_i  (meta_in),
    .pop_i   (meta_pop),
    .data_o  (meta_head),
    .full_o  (meta_full),
    .empty_o (meta_empty),
    .count_o (outstanding_o)
  );

  axi_to_mem_fifo #(.Width(DataEW), .Depth(NumOutstanding)) u_data_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (data_push),
    .data_i  (data_in),
    .pop_i   (data_pop),
    .data_o  (data_head),
    .full_o  (data_full),
    .empty_o (data_empty),
    .count_o (data_count_unused)
  );

  // Head join and resp mux; error metadata produces SLVERR without consuming memory data.
  always_comb begin
    r_valid_o = !meta_empty && (head_err || !data_empty);
    beat_data = data_head[DataWidth:1];
    beat_resp = data_head[0] ? RESP_SLVERR : RESP_OKAY;
    if (head_err) begin
      beat_data = '0;
      beat_resp = RESP_SLVERR;
    end
    beat     = {head_id, beat_data, beat_resp, head_last, head_user};
    r_data_o = r_valid_o ? beat : '0;
    fire     = r_valid_o && r_ready_i;
  end

  // Overflow pulse: memory data that arrives with the data FIFO full has been lost.
  always_comb begin
    overflow_d = mem_rvalid_i && data_full;
  end

  // Overflow pulse register.
  always_ff @(posedge clk_i) begin
    if (rst_i) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_axi_to_mem_r_assembler.sv
module tb_axi_to_mem_r_assembler;

  localparam int DW = 64;
  localparam int IW = 4;
  localparam int UW = 1;
  localparam int N  = 4;
  localparam int RW = IW + DW + 3 + UW;
  localparam int CW = $clog2(N) + 1;

  logic          clk;
  logic          rst;
  logic          meta_valid;
  logic          meta_ready;
  logic [IW-1:0] meta_id;
  logic          meta_last;
  logic [UW-1:0] meta_user;
  logic          meta_err;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          mem_err;
  logic          r_valid;
  logic          r_ready;
  logic [RW-1:0] r_data;
  logic [CW-1:0] outstanding;
  logic          overflow;

  axi_to_mem_r_assembler #(
    .DataWidth(DW), .IdWidth(IW), .UserWidth(UW), .NumOutstanding(N)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .meta_valid_i  (meta_valid),
    .meta_ready_o  (meta_ready),
    .meta_id_i     (meta_id),
    .meta_last_i   (meta_last),
    .meta_user_i   (meta_user),
    .meta_err_i    (meta_err),
    .mem_rvalid_i  (mem_rvalid),
    .mem_rdata_i   (mem_rdata),
    .mem_err_i     (mem_err),
    .r_valid_o     (r_valid),
    .r_ready_i     (r_ready),
    .r_data_o      (r_data),
    .outstanding_o (outstanding),
    .overflow_o    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model: two bounded in-order queues ----------------
  typedef struct {
    logic [IW-1:0] id;
    logic          last;
    logic [UW-1:0] user;
    logic          err;
  } mmeta_t;
  typedef struct {
    logic [DW-1:0] d;
    logic          e;
  } mdat_t;

  mmeta_t mq[$];
  mdat_t  dq[$];
  logic   m_ovf = 1'b0;
  bit     model_live = 1'b0;

  function automatic logic m_valid();
    if (mq.size() == 0) return 1'b0;
    return mq[0].err || (dq.size() > 0);
  endfunction

  function automatic logic [RW-1:0] m_beat();
    logic [DW-1:0] d;
    logic [1:0]    rs;
    if (mq.size() == 0) return '0;
    if (mq[0].err) begin
      d  = '0;
      rs = 2'b10;
    end else begin
      d  = dq[0].d;
      rs = dq[0].e ? 2'b10 : 2'b00;
    end
    return {mq[0].id, d, rs, mq[0].last, mq[0].user};
  endfunction

  task automatic model_step();
    logic   fire;
    logic   herr;
    bit     mfull;
    bit     dfull;
    mmeta_t nm;
    mdat_t  nd;
    if (rst) begin
      mq.delete();
      dq.delete();
      m_ovf = 1'b0;
      model_live = 1'b1;
    end else begin
      fire  = m_valid() && r_ready;
      herr  = (mq.size() > 0) ? mq[0].err : 1'b0;
      mfull = (mq.size() >= N);
      dfull = (dq.size() >= N);
      m_ovf = mem_rvalid && dfull;
      if (fire) begin
        void'(mq.pop_front());
        if (!herr) void'(dq.pop_front());
      end
      if (meta_valid && !mfull) begin
        nm.id = meta_id; nm.last = meta_last; nm.user = meta_user; nm.err = meta_err;
        mq.push_back(nm);
      end
      if (mem_rvalid && !dfull) begin
        nd.d = mem_rdata; nd.e = mem_err;
        dq.push_back(nd);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every cycle once the model is live.
  initial forever begin
    @(negedge clk);
    if (model_live) begin
      chk("r_valid", RW'(r_valid), RW'(m_valid()));
      chk("meta_ready", RW'(meta_ready), RW'(mq.size() < N));
      chk("outstanding", RW'(outstanding), RW'(mq.size()));
      chk("overflow", RW'(overflow), RW'(m_ovf));
      if (m_valid()) chk("r_data", r_data, m_beat());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, expected completion)");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    meta_valid = 1'b0; meta_id = '0; meta_last = 1'b0; meta_user = '0; meta_err = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
  endtask

  task automatic set_meta(input logic [IW-1:0] id, input logic last, input logic [UW-1:0] user,
                          input logic err);
    meta_valid = 1'b1; meta_id = id; meta_last = last; meta_user = user; meta_err = err;
  endtask

  task automatic set_mem(input logic [DW-1:0] d, input logic e);
    mem_rvalid = 1'b1; mem_rdata = d; mem_err = e;
  endtask

  function automatic logic [IW-1:0] f_id(input logic [RW-1:0] b);
    return b[RW-1 -: IW];
  endfunction
  function automatic logic [DW-1:0] f_data(input logic [RW-1:0] b);
    return b[UW+3 +: DW];
  endfunction
  function automatic logic [1:0] f_resp(input logic [RW-1:0] b);
    return b[UW+2 -: 2];
  endfunction
  function automatic logic f_last(input logic [RW-1:0] b);
    return b[UW];
  endfunction

  logic [RW-1:0] seen[$];

  // One cycle that also records any beat handed over at its end.
  task automatic step_collect();
    @(negedge clk);
    if (r_valid && r_ready) seen.push_back(r_data);
    tick();
  endtask

  initial begin
    logic [RW-1:0] exp1;
    int ovf_cnt;
    idle();
    r_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_r_valid", RW'(r_valid), '0);
    chk("rst_meta_ready", RW'(meta_ready), RW'(1));
    chk("rst_outstanding", RW'(outstanding), '0);
    chk("rst_overflow", RW'(overflow), '0);
    chk("rst_r_data", r_data, '0);

    // Single beat: meta then data one cycle later, beat valid the cycle after the data
    r_ready = 1'b1;
    set_meta(4'd3, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    set_mem(64'hDEAD_BEEF, 1'b0);
    tick();
    idle();
    @(negedge clk);
    exp1 = {4'd3, 64'h0000_0000_DEAD_BEEF, 2'b00, 1'b1, 1'b1};
    chk("single_valid", RW'(r_valid), RW'(1));
    chk("single_beat", r_data, exp1);
    tick();

    // Four-beat burst held back by r_ready low
    r_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 4) set_meta(IW'(i + 1), (i == 3), '0, 1'b0);
      if (i > 0) set_mem(DW'(64'h100 + i - 1), 1'b0);
      tick();
    end
    idle();
    @(negedge clk);
    chk("burst_outstanding_peak", RW'(outstanding), RW'(4));
    chk("burst_meta_ready_full", RW'(meta_ready), '0);
    tick();
    tick();
    tick();
    r_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("burst_id", RW'(f_id(r_data)), RW'(i + 1));
      chk("burst_data", RW'(f_data(r_data)), RW'(64'h100 + i));
      chk("burst_last", RW'(f_last(r_data)), RW'(i == 3));
      if (i == 1) chk("meta_ready_after_pop", RW'(meta_ready), RW'(1));
      tick();
    end

    // Error beat between two good beats
    seen.delete();
    idle(); set_meta(4'd6, 1'b0, '0, 1'b0);                           step_collect();
    idle(); set_meta(4'd7, 1'b0, '0, 1'b1); set_mem(64'hA, 1'b0);     step_collect();
    idle(); set_meta(4'd8, 1'b1, '0, 1'b0);                           step_collect();
    idle(); set_mem(64'hB, 1'b0);                                     step_collect();
    idle();
    for (int i = 0; i < 6; i++) step_collect();
    chk("err_mid_count", RW'(seen.size()), RW'(3));
    if (seen.size() == 3) begin
      chk("err_mid_id0", RW'(f_id(seen[0])), RW'(6));
      chk("err_mid_resp0", RW'(f_resp(seen[0])), RW'(2'b00));
      chk("err_mid_data0", RW'(f_data(seen[0])), RW'(64'hA));
      chk("err_mid_id1", RW'(f_id(seen[1])), RW'(7));
      chk("err_mid_resp1", RW'(f_resp(seen[1])), RW'(2'b10));
      chk("err_mid_data1", RW'(f_data(seen[1])), '0);
      chk("err_mid_id2", RW'(f_id(seen[2])), RW'(8));
      chk("err_mid_data2", RW'(f_data(seen[2])), RW'(64'hB));
    end

    // Memory error: SLVERR with the data passed through
    set_meta(4'd2, 1'b1, '0, 1'b0);
    tick();
    idle();
    set_mem(64'h1234, 1'b1);
    tick();
    idle();
    @(negedge clk);
    chk("memerr_resp", RW'(f_resp(r_data)), RW'(2'b10));
    chk("memerr_data", RW'(f_data(r_data)), RW'(64'h1234));
    tick();

    // Five memory beats with no pop: exactly one overflow pulse
    r_ready = 1'b0;
    ovf_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i < 4) set_meta(IW'(9 + i), (i == 3), '0, 1'b0);
      if (i < 5) set_mem(DW'(64'h200 + i), 1'b0);
      @(negedge clk);
      if (overflow) ovf_cnt++;
      tick();
    end
    idle();
    chk("overflow_pulses", RW'(ovf_cnt), RW'(1));

    // Reset while beats are pending
    @(negedge clk);
    chk("pre_reset_valid", RW'(r_valid), RW'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_r_valid", RW'(r_valid), '0);
    chk("midrst_outstanding", RW'(outstanding), '0);
    chk("midrst_meta_ready", RW'(meta_ready), RW'(1));
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axi_to_mem_r_assembler.md
# axi_to_mem_r_assembler

Builds AXI R-channel beats for the axi_to_mem bridge by joining per-beat metadata, pushed when a memory read is issued, with the un-stallable memory read responses. It sits directly upstream of the R-channel spill register and drives that register's valid/ready/data input with the packed beat `{id, data, resp[1:0], last, user}`. Both streams are buffered in order so the memory side never sees backpressure.

## Interface
- DataWidth, 64, memory/R data width
- IdWidth, 4, AXI ID width
- UserWidth, 1, AXI user width
- NumOutstanding, 4, depth of both internal FIFOs (power of two, ≥2)
- clk_i  in  1  single clock
- rst_i  in  1  one clock, clk_i; reset rst_i is synchronous and active-high
- meta_valid_i  in  1  metadata push request
- meta_ready_o  out  1  metadata FIFO not full
- meta_id_i  in  IdWidth  beat ID
- meta_last_i  in  1  beat is last of burst
- meta_user_i  in  UserWidth  beat user bits
- meta_err_i  in  1  beat has no memory access; produce SLVERR locally
- mem_rvalid_i  in  1  memory read data valid (cannot be stalled)
- mem_rdata_i  in  DataWidth  memory read data
- mem_err_i  in  1  memory reported error for this beat
- r_valid_o  out  1  beat valid toward the spill register
- r_ready_i  in  1  spill register ready
- r_data_o  out  IdWidth+DataWidth+3+UserWidth  packed beat, MSB first: id, data, resp, last, user
- outstanding_o  out  $clog2(NumOutstanding)+1  metadata FIFO occupancy
- overflow_o  out  1  one-cycle pulse: memory data arrived with the data FIFO full

## Operation
- Meta FIFO entry: {id, last, user, err}. Data FIFO entry: {data, mem_err}.
- Push meta on meta_valid_i && meta_ready_o. Push data on mem_rvalid_i when the data FIFO is not full.
- Issuer contract: it pushes meta in the same cycle it issues the memory request, and only when meta_ready_o=1. Memory data therefore never outruns the metadata.
- Head join: r_valid_o = !meta_empty && (meta_head.err || !data_empty).
- Resp: meta_head.err → 2'b10 with data forced to 0. Otherwise mem_err → 2'b10, else 2'b00 (OKAY).
- On r_valid_o && r_ready_i:
  - pop meta;
  - pop data only if meta_head.err=0.
- r_data_o is driven combinationally from the FIFO heads and is held stable while r_valid_o=1 and r_ready_i=0.
- meta_ready_o = !meta_full. It does not depend on a same-cycle pop, so there is no ready→valid combinational path.
- Data FIFO full and mem_rvalid_i=1: the beat is dropped and overflow_o pulses in the next cycle. This is a protocol violation; the block does not recover.
- Pointers wrap modulo NumOutstanding. Count width allows the value NumOutstanding.

## Timing
- Reset: all FIFOs empty; r_valid_o=0, meta_ready_o=1, outstanding_o=0, overflow_o=0, r_data_o=0.
- Reset mid-operation discards all buffered entries. The first cycle after rst_i deasserts behaves like post-reset.
- Latency:
  - mem_rvalid_i in cycle t (meta already present) → r_valid_o=1 in t+1.
  - Error meta pushed in cycle t → r_valid_o=1 in t+1.
- Throughput: one beat per cycle sustained with r_ready_i=1.
- Simultaneous push and pop on the meta FIFO when full: the pop occurs, the push is refused (meta_ready_o was 0), and occupancy becomes NumOutstanding−1.
- Simultaneous push and pop on either FIFO when non-full: occupancy is unchanged.

## Structure
- Shared package axi_to_mem_pkg holds:
  - resp constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - the r-beat width and packing function, shared with the spill register instance.
- One sub-module, axi_to_mem_fifo: synchronous FIFO parameterised by width and depth, with full, empty and count. It is instantiated twice, for meta and data.
- Top level contains the join logic, resp muxing and overflow pulse register.

## Test plan
- Single beat: meta {id=3, last=1, err=0}, then data 0xDEAD_BEEF one cycle later → r_data_o {3, 0xDEADBEEF, 00, 1, user} one cycle after the data.
- Four-beat burst with r_ready_i low for 3 cycles → beats emitted in order, each held stable; last=1 only on beat 4; outstanding_o peaks at 4.
- Error beat between two good beats → middle beat has resp=10 and data=0; the data FIFO pops only twice.
- Fill meta to 4 with r_ready_i=0 → meta_ready_o=0. Assert r_ready_i → meta_ready_o=1 the next cycle.
- mem_rvalid_i with mem_err_i=1 → resp=10 and data is passed through unchanged.
- Inject 5 memory beats without a pop → overflow_o pulses exactly once. Asserting rst_i mid-burst → r_valid_o=0 and outstanding_o=0 the next cycle.
